// File: rtl/a2d_intf.sv
// SPI master for the ADC128S: each nxt request converts channels 0, 4 and 5
// (two 16-bit transactions each) and presents the three 12-bit results with a vld strobe.
module a2d_intf #(
  parameter int SCLK_DIV = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nxt,
  input  logic        MISO,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] batt,
  output logic        vld,
  output logic        busy
);

  localparam int H  = SCLK_DIV / 2;
  localparam int DW = $clog2(SCLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(H - 1);

  typedef enum logic [2:0] {IDLE, FRONT, SHIFT, BACK, GAP} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [15:0]   tx_q, tx_d;
  logic [11:0]   rx_q, rx_d;
  logic [11:0]   lft_stage_q, lft_stage_d;
  logic [11:0]   rght_stage_q, rght_stage_d;
  logic [11:0]   lft_ld_q, lft_ld_d;
  logic [11:0]   rght_ld_q, rght_ld_d;
  logic [11:0]   batt_q, batt_d;
  logic          ss_n_q, ss_n_d;
  logic          sclk_q, sclk_d;
  logic          vld_q, vld_d;
  logic          phase_end;
  logic [2:0]    idx_inc;

  function automatic logic [15:0] cmd_word(input logic [1:0] pair);
    logic [2:0] ch;
    case (pair)
      2'd0:    ch = 3'd0;
      2'd1:    ch = 3'd4;
      default: ch = 3'd5;
    endcase
    return {2'b00, ch, 11'h000};
  endfunction

  assign phase_end = (div_q == DIV_LAST);
  assign idx_inc   = idx_q + 3'd1;

  always_comb begin
    state_d      = state_q;
    div_d        = '0;
    bit_cnt_d    = bit_cnt_q;
    idx_d        = idx_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    lft_stage_d  = lft_stage_q;
    rght_stage_d = rght_stage_q;
    lft_ld_d     = lft_ld_q;
    rght_ld_d    = rght_ld_q;
    batt_d       = batt_q;
    ss_n_d       = ss_n_q;
    sclk_d       = sclk_q;
    vld_d        = 1'b0;

    if (state_q != IDLE) begin
      div_d = phase_end ? '0 : div_q + DW'(1);
    end

    case (state_q)
      IDLE: begin
        ss_n_d = 1'b1;
        sclk_d = 1'b1;
        if (nxt) begin
          state_d   = FRONT;
          ss_n_d    = 1'b0;
          idx_d     = 3'd0;
          bit_cnt_d = 4'd0;
          tx_d      = cmd_word(2'd0);
        end
      end
      FRONT: begin
        if (phase_end) begin
          state_d = SHIFT;
          sclk_d  = 1'b0;
        end
      end
      SHIFT: begin
        if (phase_end) begin
          if (!sclk_q) begin
            // Only 12 RX bits are kept: the upper nibble shifts out the top.
            sclk_d    = 1'b1;
            rx_d      = {rx_q[10:0], MISO};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (bit_cnt_q == 4'd0) begin
            state_d = BACK;
          end else begin
            sclk_d = 1'b0;
            tx_d   = {tx_q[14:0], 1'b0};
          end
        end
      end
      BACK: begin
        if (phase_end) begin
          if (idx_q[0]) begin
            case (idx_q[2:1])
              2'd0:    lft_stage_d  = rx_q;
              2'd1:    rght_stage_d = rx_q;
              default: ;
            endcase
          end
          ss_n_d = 1'b1;
          if (idx_q == 3'd5) begin
            // The battery result is taken straight from RX as its staging slot is this cycle.
            state_d   = IDLE;
            vld_d     = 1'b1;
            lft_ld_d  = lft_stage_q;
            rght_ld_d = rght_stage_q;
            batt_d    = rx_q;
          end else begin
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (phase_end) begin
          state_d = FRONT;
          ss_n_d  = 1'b0;
          idx_d   = idx_inc;
          tx_d    = cmd_word(idx_inc[2:1]);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      div_q        <= '0;
      bit_cnt_q    <= '0;
      idx_q        <= '0;
      tx_q         <= '0;
      rx_q         <= '0;
      lft_stage_q  <= '0;
      rght_stage_q <= '0;
      lft_ld_q     <= '0;
      rght_ld_q    <= '0;
      batt_q       <= '0;
      ss_n_q       <= 1'b1;
      sclk_q       <= 1'b1;
      vld_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      bit_cnt_q    <= bit_cnt_d;
      idx_q        <= idx_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      lft_stage_q  <= lft_stage_d;
      rght_stage_q <= rght_stage_d;
      lft_ld_q     <= lft_ld_d;
      rght_ld_q    <= rght_ld_d;
      batt_q       <= batt_d;
      ss_n_q       <= ss_n_d;
      sclk_q       <= sclk_d;
      vld_q        <= vld_d;
    end
  end

  assign SS_n    = ss_n_q;
  assign SCLK    = sclk_q;
  assign MOSI    = tx_q[15];
  assign lft_ld  = lft_ld_q;
  assign rght_ld = rght_ld_q;
  assign batt    = batt_q;
  assign vld     = vld_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_a2d_intf.sv
// Bench for a2d_intf: an SPI slave model on the default-divider instance plus a
// small SCLK_DIV=4 instance; every expectation is a hand-computed constant.
module tb_a2d_intf;

  localparam int H       = 16;
  localparam int LATENCY = 1 + 209 * H;

  typedef struct {
    logic [15:0] words [6];
    logic [11:0] lft;
    logic [11:0] rght;
    logic [11:0] batt;
  } round_vec_t;

  logic clk = 1'b0;
  logic rst, nxt, MISO;
  logic SS_n, SCLK, MOSI, vld, busy;
  logic [11:0] lft_ld, rght_ld, batt;

  logic nxt_f, MISO_f;
  logic SS_n_f, SCLK_f, MOSI_f, vld_f, busy_f;
  logic [11:0] lft_ld_f, rght_ld_f, batt_f;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  a2d_intf dut (
    .clk(clk), .rst(rst), .nxt(nxt), .MISO(MISO),
    .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
    .lft_ld(lft_ld), .rght_ld(rght_ld), .batt(batt),
    .vld(vld), .busy(busy)
  );

  a2d_intf #(.SCLK_DIV(4)) dut_fast (
    .clk(clk), .rst(rst), .nxt(nxt_f), .MISO(MISO_f),
    .SS_n(SS_n_f), .SCLK(SCLK_f), .MOSI(MOSI_f),
    .lft_ld(lft_ld_f), .rght_ld(rght_ld_f), .batt(batt_f),
    .vld(vld_f), .busy(busy_f)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] cmd_exp [6] = '{16'h0000, 16'h0000, 16'h2000, 16'h2000, 16'h2800, 16'h2800};
  logic [15:0] slave_words [6];
  round_vec_t  vecs [3];

  // Slave model and bus monitor state, all sampled on the falling clock edge.
  logic [15:0] mosi_q [$];
  int win_len_q [$], rises_q [$], falls_q [$], ffall_q [$], gap_q [$];
  int win_start = 0, rises = 0, falls = 0, ffall = 0, last_rise = -1, last_end = 0;
  int txn_idx = 0, period_err = 0, sclk_glitch = 0, out_glitch = 0, vld_cnt = 0, ss_falls = 0;
  bit have_end = 1'b0, ss_prev = 1'b1, sclk_prev = 1'b1;
  logic [15:0] mosi_word = '0, cur_word = '0;
  logic [35:0] out_prev = '0;

  always @(negedge clk) begin
    if (ss_prev && !SS_n) begin
      ss_falls++;
      if (have_end) gap_q.push_back(cyc - last_end);
      win_start = cyc; rises = 0; falls = 0; ffall = -1; last_rise = -1; mosi_word = '0;
      cur_word = (txn_idx < 6) ? slave_words[txn_idx] : 16'h0000;
      MISO = cur_word[15];
    end
    if (!SS_n && sclk_prev && !SCLK) begin
      if (falls == 0) ffall = cyc - win_start;
      falls++;
      if (rises < 16) MISO = cur_word[15 - rises];
    end
    if (!SS_n && !sclk_prev && SCLK) begin
      mosi_word = {mosi_word[14:0], MOSI};
      if (last_rise >= 0 && (cyc - last_rise) != 2 * H) period_err++;
      last_rise = cyc;
      rises++;
    end
    if (!ss_prev && SS_n) begin
      mosi_q.push_back(mosi_word);
      win_len_q.push_back(cyc - win_start);
      rises_q.push_back(rises);
      falls_q.push_back(falls);
      ffall_q.push_back(ffall);
      last_end = cyc;
      have_end = 1'b1;
      txn_idx++;
    end
    if (SS_n && ss_prev && (SCLK != sclk_prev)) sclk_glitch++;
    if (vld) vld_cnt++;
    if (!rst && !vld && ({lft_ld, rght_ld, batt} != out_prev)) out_glitch++;
    out_prev  = {lft_ld, rght_ld, batt};
    ss_prev   = SS_n;
    sclk_prev = SCLK;
  end

  int rises_f = 0, per_err_f = 0, last_rise_f = -1;
  bit ss_f_prev = 1'b1, sclk_f_prev = 1'b1;

  always @(negedge clk) begin
    if (ss_f_prev && !SS_n_f) last_rise_f = -1;
    if (!SS_n_f && !sclk_f_prev && SCLK_f) begin
      if (last_rise_f >= 0 && (cyc - last_rise_f) != 4) per_err_f++;
      last_rise_f = cyc;
      rises_f++;
    end
    ss_f_prev   = SS_n_f;
    sclk_f_prev = SCLK_f;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(output int t);
    @(negedge clk);
    nxt = 1'b1;
    t = cyc;
    @(negedge clk);
    nxt = 1'b0;
  endtask

  task automatic waitVld(input int budget, output int at, output bit ok);
    ok = 1'b0;
    at = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (vld) begin
        ok = 1'b1;
        at = cyc;
      end
    end
    if (!ok) checkOutput("vld_timeout", 0, 1);
  endtask

  task automatic prepRound(input round_vec_t v);
    slave_words = v.words;
    mosi_q.delete(); win_len_q.delete(); rises_q.delete();
    falls_q.delete(); ffall_q.delete(); gap_q.delete();
    txn_idx = 0;
    have_end = 1'b0;
    period_err = 0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_SS_n"}, SS_n, 1);
    checkOutput({tag, "_SCLK"}, SCLK, 1);
    checkOutput({tag, "_MOSI"}, MOSI, 0);
    checkOutput({tag, "_lft"}, lft_ld, 0);
    checkOutput({tag, "_rght"}, rght_ld, 0);
    checkOutput({tag, "_batt"}, batt, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_vld"}, vld, 0);
  endtask

  task automatic checkRound(input round_vec_t v, input int lat);
    checkOutput("latency", lat, LATENCY);
    checkOutput("lft_ld", lft_ld, v.lft);
    checkOutput("rght_ld", rght_ld, v.rght);
    checkOutput("batt", batt, v.batt);
    checkOutput("windows", mosi_q.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < mosi_q.size()) begin
        checkOutput($sformatf("cmd[%0d]", i), mosi_q[i], cmd_exp[i]);
        checkOutput($sformatf("ss_low_len[%0d]", i), win_len_q[i], 34 * H);
        checkOutput($sformatf("sclk_rises[%0d]", i), rises_q[i], 16);
        checkOutput($sformatf("sclk_falls[%0d]", i), falls_q[i], 16);
        checkOutput($sformatf("first_fall[%0d]", i), ffall_q[i], H);
      end
    end
    checkOutput("gaps", gap_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < gap_q.size()) checkOutput($sformatf("gap_len[%0d]", i), gap_q[i], H);
    end
    checkOutput("sclk_period_err", period_err, 0);
  endtask

  initial begin
    int t, at, at2, v0, f0;
    bit ok;
    logic [35:0] held;

    vecs[0].words = '{16'h0001, 16'h0001, 16'h0030, 16'h0030, 16'hFFFF, 16'h0FFF};
    vecs[0].lft = 12'h001; vecs[0].rght = 12'h030; vecs[0].batt = 12'hFFF;
    vecs[1].words = '{16'hFFFF, 16'h0000, 16'h1234, 16'h5555, 16'h8000, 16'h7AAA};
    vecs[1].lft = 12'h000; vecs[1].rght = 12'h555; vecs[1].batt = 12'hAAA;
    vecs[2].words = '{16'h0ABC, 16'h0123, 16'h0456, 16'hF789, 16'h0DEF, 16'hA321};
    vecs[2].lft = 12'h123; vecs[2].rght = 12'h789; vecs[2].batt = 12'h321;

    rst = 1'b1; nxt = 1'b0; MISO = 1'b1; nxt_f = 1'b0; MISO_f = 1'b1;
    repeat (2) @(negedge clk);
    checkResetState("init");
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] table-driven rounds");
    for (int i = 0; i < 3; i++) begin
      prepRound(vecs[i]);
      v0 = vld_cnt;
      applyStimulus(t);
      waitVld(4000, at, ok);
      repeat (2) @(negedge clk);
      checkOutput($sformatf("vld_pulses[%0d]", i), vld_cnt - v0, 1);
      checkRound(vecs[i], at - t);
    end

    $display("[TB] nxt while busy is ignored");
    prepRound(vecs[0]);
    held = {lft_ld, rght_ld, batt};
    v0 = vld_cnt;
    f0 = ss_falls;
    applyStimulus(t);
    repeat (98) @(negedge clk);
    nxt = 1'b1; @(negedge clk); nxt = 1'b0;
    repeat (1899) @(negedge clk);
    nxt = 1'b1; @(negedge clk); nxt = 1'b0;
    repeat (1000) @(negedge clk);
    checkOutput("hold_outputs", {lft_ld, rght_ld, batt} == held, 1);
    waitVld(4000, at, ok);
    repeat (2) @(negedge clk);
    checkRound(vecs[0], at - t);
    repeat (3400) @(negedge clk);
    checkOutput("ignore_vld_count", vld_cnt - v0, 1);
    checkOutput("ignore_ss_windows", ss_falls - f0, 6);
    checkOutput("ignore_busy", busy, 0);

    $display("[TB] back-to-back rounds");
    prepRound(vecs[1]);
    applyStimulus(t);
    waitVld(4000, at, ok);
    checkOutput("b2b_first_latency", at - t, LATENCY);
    checkOutput("b2b_first_lft", lft_ld, vecs[1].lft);
    checkOutput("b2b_first_rght", rght_ld, vecs[1].rght);
    checkOutput("b2b_first_batt", batt, vecs[1].batt);
    #1;
    prepRound(vecs[2]);
    nxt = 1'b1;
    @(negedge clk);
    nxt = 1'b0;
    checkOutput("b2b_ss_low", SS_n, 0);
    checkOutput("b2b_busy", busy, 1);
    waitVld(4000, at2, ok);
    repeat (2) @(negedge clk);
    checkRound(vecs[2], at2 - at);

    $display("[TB] reset during SHIFT");
    prepRound(vecs[0]);
    v0 = vld_cnt;
    applyStimulus(t);
    repeat (300) @(negedge clk);
    checkOutput("pre_reset_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    checkResetState("midreset");
    @(negedge clk);
    rst = 1'b0;
    f0 = ss_falls;
    repeat (4000) @(negedge clk);
    checkOutput("post_reset_vld", vld_cnt - v0, 0);
    checkOutput("post_reset_ss", ss_falls - f0, 0);
    checkResetState("post_reset");

    $display("[TB] SCLK_DIV=4 instance");
    rises_f = 0;
    per_err_f = 0;
    @(negedge clk);
    nxt_f = 1'b1;
    t = cyc;
    @(negedge clk);
    nxt_f = 1'b0;
    ok = 1'b0;
    at = 0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clk);
      if (vld_f) begin
        ok = 1'b1;
        at = cyc;
      end
    end
    checkOutput("fast_vld_seen", ok, 1);
    checkOutput("fast_latency", at - t, 419);
    checkOutput("fast_lft", lft_ld_f, 12'hFFF);
    checkOutput("fast_rght", rght_ld_f, 12'hFFF);
    checkOutput("fast_batt", batt_f, 12'hFFF);
    checkOutput("fast_rises", rises_f, 96);
    checkOutput("fast_period_err", per_err_f, 0);

    checkOutput("sclk_toggle_while_ss_high", sclk_glitch, 0);
    checkOutput("outputs_changed_without_vld", out_glitch, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
